// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: shared pipeline types, scoreboard entry layout and the canonical NOP.
package otter_pipe_pkg;
  localparam int RA_MAX = 16;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;
  typedef logic [31:0] instr_t;
  typedef struct packed {
    logic              valid;
    logic [RA_MAX-1:0] rd;
    logic              is_load;
  } sb_entry_t;
  localparam instr_t NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/otter_fwd_match.sv
// otter_fwd_match: finds the youngest scoreboard entry producing one source operand.
module otter_fwd_match
  import otter_pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int KW    = 2
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [RA_MAX-1:0]     src,
  input  logic                  used,
  output logic                  hit,
  output logic [KW-1:0]         k,
  output logic                  is_load
);
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit     = 1'b0;
    k       = '0;
    is_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (used && sb[i].valid && sb[i].rd != '0 && sb[i].rd == src) begin
        hit     = 1'b1;
        k       = KW'(i + 1);
        is_load = sb[i].is_load;
      end
  end
endmodule

// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl: stall/bubble/flush and forwarding-select control for the OTTER pipeline.
// Define OTTER_FWD_EN to enable operand forwarding; otherwise producers are ready at WB.
module otter_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int RA_W     = 5
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         de_valid,
  input  logic [RA_W-1:0]              de_rs1_addr,
  input  logic [RA_W-1:0]              de_rs2_addr,
  input  logic                         de_rs1_used,
  input  logic                         de_rs2_used,
  input  logic [RA_W-1:0]              de_rd_addr,
  input  logic                         de_rd_used,
  input  logic                         de_is_load,
  input  logic                         ex_redirect,
  input  logic                         mem_wait,
  output logic                         stall_fd,
  output logic                         bubble_ex,
  output logic                         flush_fd,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b_sel,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
);
  localparam int KW = $clog2(DEPTH + 1);
`ifdef OTTER_FWD_EN
  localparam bit FWD    = 1'b1;
  localparam int RDY_AL = 1;
  localparam int RDY_LD = LOAD_LAT;
`else
  localparam bit FWD    = 1'b0;
  localparam int RDY_AL = DEPTH;
  localparam int RDY_LD = DEPTH;
`endif
  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             new_e;
  logic                  hit_a, hit_b, ld_a, ld_b, hazard, fwd_gate;
  logic [KW-1:0]         k_a, k_b, rdy_a, rdy_b;
  otter_fwd_match #(.DEPTH(DEPTH), .KW(KW)) u_match_a (
    .sb(sb), .src(RA_MAX'(de_rs1_addr)), .used(de_rs1_used),
    .hit(hit_a), .k(k_a), .is_load(ld_a)
  );
  otter_fwd_match #(.DEPTH(DEPTH), .KW(KW)) u_match_b (
    .sb(sb), .src(RA_MAX'(de_rs2_addr)), .used(de_rs2_used),
    .hit(hit_b), .k(k_b), .is_load(ld_b)
  );
  always_comb begin
    rdy_a     = ld_a ? KW'(RDY_LD) : KW'(RDY_AL);
    rdy_b     = ld_b ? KW'(RDY_LD) : KW'(RDY_AL);
    hazard    = de_valid && ((hit_a && k_a < rdy_a) || (hit_b && k_b < rdy_b));
    fwd_gate  = RESET_N && FWD && (de_valid || ex_redirect || mem_wait);
    fwd_a_sel = (fwd_gate && hit_a) ? k_a : '0;
    fwd_b_sel = (fwd_gate && hit_b) ? k_b : '0;
    stall_fd  = RESET_N && (mem_wait || (!ex_redirect && hazard));
    bubble_ex = RESET_N && !mem_wait && (ex_redirect || hazard);
    flush_fd  = RESET_N && !mem_wait && ex_redirect;
    new_e     = sb_entry_t'{valid: de_valid && !bubble_ex,
                            rd: de_rd_used ? RA_MAX'(de_rd_addr) : '0,
                            is_load: de_is_load};
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      sb        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_wait) begin
      sb[0] <= new_e;
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
      if (ex_redirect) flush_cnt <= flush_cnt + 32'd1;
      else if (hazard) stall_cnt <= stall_cnt + 32'd1;
    end
endmodule
